sens_event_arbiter: RTL
=======================

Name: sens_event_arbiter

Overview:
- Sequential controller for a sensitivity-list style datapath of the form out = (a | b) & (c | d).
- Watches N_SRC level signals, sampled synchronously, and turns every value change into a pending event.
- Round-robin arbitration hands one event at a time to a downstream evaluator over a valid/ready handshake.
- Keeps a registered copy of the function result, updated on every accepted event. Sits between the raw input nets and the evaluator/logger.

Parameters:
- N_SRC, 4: number of watched sources; must be even and ≥ 2.
- CNT_W, 8: width of the saturating coalesce counter.
- IDX_W, $clog2(N_SRC): width of the event index; derived, not overridable.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- sig_i  input  N_SRC  watched levels, already synchronous to clk
- evt_valid_o  output  1  event offered
- evt_ready_i  input  1  downstream accepts event
- evt_idx_o  output  IDX_W  source that changed
- evt_snap_o  output  N_SRC  sig_q snapshot captured when the event was loaded
- eval_o  output  1  registered (|snap[N_SRC/2-1:0]) & (|snap[N_SRC-1:N_SRC/2]), updated on each handshake
- pend_o  output  N_SRC  pending event bits, for debug
- coal_cnt_o  output  CNT_W  saturating count of coalesced (lost) events
- coal_o  output  1  sticky: at least one coalesce since reset

Behaviour:
- Reset (async, rst_n=0) clears everything to 0:
  - state = IDLE, sig_q, pend, evt_valid_o, evt_idx_o, evt_snap_o, eval_o, coal_cnt_o, coal_o, rr_ptr, armed.
- Arming:
  - The first clock after reset release loads sig_q <= sig_i and sets armed=1.
  - No events are generated on that cycle, so static non-zero inputs produce no spurious events.
- Change detect, every cycle once armed:
  - chg = sig_i ^ sig_q
  - sig_q <= sig_i
- Pending update:
  - pend <= (pend & ~clr) | chg, where clr is the one-hot mask of the source loaded this cycle.
  - Set wins over clear: a change on the source being loaded leaves its bit pending.
- Coalesce:
  - Applies to any bit with chg & pend & ~clr.
  - coal_cnt_o increments by 1 per cycle in which at least one such bit exists; it is not a per-bit count.
  - coal_cnt_o saturates at 2^CNT_W-1; coal_o is set and stays set.
- Arbitration:
  - Round-robin search starts at rr_ptr and wraps modulo N_SRC.
  - The winner w is the first set bit of pend.
  - On load, rr_ptr <= (w+1) mod N_SRC.
- FSM, IDLE state:
  - If |pend: load evt_idx_o=w, evt_snap_o=sig_q, clr=onehot(w), evt_valid_o=1, go to OFFER.
  - Otherwise stay in IDLE.
- FSM, OFFER state:
  - evt_valid_o, evt_idx_o and evt_snap_o hold stable until evt_ready_i=1 (AXI-style: valid does not drop without ready).
  - On handshake, eval_o <= function(evt_snap_o).
  - On handshake with |pend (current pend register): load the next winner in the same cycle (back-to-back, 1 event/cycle); stay in OFFER.
  - On handshake with pend==0: evt_valid_o <= 0, go to IDLE.
- Latency: a change sampled at edge t becomes pending at edge t+1 and is offered from edge t+2 if the FSM is idle.
- Reset mid-OFFER drops the offered event and all pending events immediately; operation restarts with the arming cycle.
- evt_ready_i is ignored while evt_valid_o=0.

Decomposition:
- Package sens_evt_pkg holds:
  - the state enum (IDLE, OFFER)
  - the eval function (half-OR AND)
  - the default parameter constants
- One sub-module, rr_pick: given pend and rr_ptr, returns the winner index and a found flag. It is purely combinational and reusable by other arbiters.

Test Plan:
- Arming: rst_n released with sig_i=4'b1010 held constant for 20 cycles -> evt_valid_o never rises; pend_o=0.
- Single event: arm with sig_i=0, toggle bit 2 to 1, evt_ready_i=1 -> evt_valid_o=1 two edges later with idx=2, snap=4'b0100. After handshake, eval_o=0 and the FSM returns to IDLE.
- Fairness: simultaneous change 4'b0000->4'b1111, rr_ptr=0, ready=1 -> idx sequence 0,1,2,3 on consecutive cycles, then evt_valid_o=0. The last handshake leaves eval_o=1.
- Backpressure: event on bit 1 with ready=0 for 5 cycles -> valid, idx and snap stable for all 5 cycles; accepted on the 6th cycle when ready=1.
- Coalesce: hold ready=0 and toggle bit 3 on three separate cycles while pending -> coal_cnt_o=2, coal_o=1; only one bit-3 event is delivered. With CNT_W=2 and 5 coalesces, coal_cnt_o saturates at 3.
- Reset mid-OFFER: assert rst_n=0 while valid=1 and pend=4'b0110 -> all outputs 0 asynchronously. After release, the arming cycle runs and no stale event is offered.

Source files
------------

// File: rtl/sens_evt_pkg.sv
// -----------------------------------------------------------------------------
// sens_evt_pkg
//   Shared types and helpers for the sensitivity-list event arbiter.
//
//   Contents:
//     N_SRC_DEF / CNT_W_DEF : default parameter values for sens_event_arbiter
//     MAX_SRC               : widest source vector the eval helper accepts
//     state_t               : arbiter FSM states (IDLE, OFFER)
//     half_or_and()         : the evaluated function (a | b) & (c | d),
//                             generalised to "OR of low half AND OR of high
//                             half" of an n-bit snapshot
// -----------------------------------------------------------------------------
package sens_evt_pkg;

  localparam int N_SRC_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam int MAX_SRC   = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  // Only the low n bits of snap are meaningful; n is expected to be even.
  function automatic logic half_or_and(input logic [MAX_SRC-1:0] snap,
                                       input int                 n);
    logic lo;
    logic hi;
    lo = 1'b0;
    hi = 1'b0;
    for (int i = 0; i < MAX_SRC; i++) begin
      if (i < n / 2) begin
        lo = lo | snap[i];
      end else if (i < n) begin
        hi = hi | snap[i];
      end
    end
    return lo & hi;
  endfunction

endpackage

// File: rtl/sens_event_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Scans req starting at ptr, wrapping
//   modulo N, and returns the first set bit.
//
//   Parameters:
//     N     : number of requesters
//     IDX_W : width of the index (derived from N)
//   Ports:
//     req   : request vector
//     ptr   : index where the search starts
//     idx   : winning index (0 when nothing is requested)
//     found : at least one request bit is set
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter  int N     = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  int unsigned pos;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; otherwise synthesis infers a latch.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = (int'(ptr) + k) % N;
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sens_event_arbiter.sv
// -----------------------------------------------------------------------------
// sens_event_arbiter
//   Watches N_SRC synchronous level signals, turns every value change into a
//   pending event and hands the events one at a time to a downstream
//   evaluator over a valid/ready handshake, in round-robin order. A registered
//   copy of the datapath result (|low_half) & (|high_half) of each accepted
//   snapshot is kept on eval_o. Changes that hit an already pending source are
//   merged into it and counted as coalesced.
//
//   Parameters:
//     N_SRC : number of watched sources (even, >= 2)
//     CNT_W : width of the saturating coalesce counter
//     IDX_W : event index width, derived from N_SRC
//   Ports:
//     clk         : clock
//     rst_n       : asynchronous active-low reset
//     sig_i       : watched levels, synchronous to clk
//     evt_valid_o : event offered
//     evt_ready_i : downstream accepts the offered event
//     evt_idx_o   : index of the source that changed
//     evt_snap_o  : sig_q snapshot captured when the event was loaded
//     eval_o      : function of the last accepted snapshot
//     pend_o      : pending event bits (debug)
//     coal_cnt_o  : saturating count of cycles with coalesced events
//     coal_o      : sticky, at least one coalesce since reset
// -----------------------------------------------------------------------------
module sens_event_arbiter
  import sens_evt_pkg::*;
#(
  parameter  int N_SRC = N_SRC_DEF,
  parameter  int CNT_W = CNT_W_DEF,
  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SRC-1:0] sig_i,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [IDX_W-1:0] evt_idx_o,
  output logic [N_SRC-1:0] evt_snap_o,
  output logic             eval_o,
  output logic [N_SRC-1:0] pend_o,
  output logic [CNT_W-1:0] coal_cnt_o,
  output logic             coal_o
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SRC - 1);

  state_t           state;
  state_t           state_nxt;
  logic [N_SRC-1:0] sig_q;
  logic [N_SRC-1:0] pend;
  logic [N_SRC-1:0] pend_nxt;
  logic [N_SRC-1:0] chg;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] coal_hit;
  logic             armed;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] win_idx;
  logic             win_found;
  logic             hs;
  logic             load;
  logic             drop;

  // Winner among the current pending bits, searched from rr_ptr.
  rr_pick #(
    .N (N_SRC)
  ) u_pick (
    .req   (pend),
    .ptr   (rr_ptr),
    .idx   (win_idx),
    .found (win_found)
  );

  // Next-state and datapath control.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drop      = 1'b0;
    clr       = '0;
    hs        = evt_valid_o & evt_ready_i;
    // The arming cycle only captures the inputs, so levels already present at
    // reset release never look like changes.
    chg       = armed ? (sig_i ^ sig_q) : '0;

    case (state)
      IDLE: begin
        if (win_found) begin
          load      = 1'b1;
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        // Valid is held until accepted; a handshake with more work pending
        // reloads immediately so the stream runs at one event per cycle.
        if (hs) begin
          if (win_found) begin
            load = 1'b1;
          end else begin
            drop      = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (load) begin
      clr[win_idx] = 1'b1;
    end

    // A change on the source being loaded this cycle survives the clear.
    pend_nxt = (pend & ~clr) | chg;
    coal_hit = chg & pend & ~clr;
  end

  // NOTE: sequential state is assigned with non-blocking (<=) only, so every
  // register samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sig_q       <= '0;
      pend        <= '0;
      armed       <= 1'b0;
      rr_ptr      <= '0;
      evt_valid_o <= 1'b0;
      evt_idx_o   <= '0;
      evt_snap_o  <= '0;
      eval_o      <= 1'b0;
      coal_cnt_o  <= '0;
      coal_o      <= 1'b0;
    end else begin
      state <= state_nxt;
      sig_q <= sig_i;
      armed <= 1'b1;
      pend  <= pend_nxt;

      if (hs) begin
        eval_o <= half_or_and(MAX_SRC'(evt_snap_o), N_SRC);
      end

      if (load) begin
        evt_valid_o <= 1'b1;
        evt_idx_o   <= win_idx;
        evt_snap_o  <= sig_q;
        rr_ptr      <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
      end else if (drop) begin
        evt_valid_o <= 1'b0;
      end

      // One increment per cycle with any coalesce, not one per bit.
      if (|coal_hit) begin
        coal_o <= 1'b1;
        if (coal_cnt_o != CNT_MAX) begin
          coal_cnt_o <= coal_cnt_o + 1'b1;
        end
      end
    end
  end

  assign pend_o = pend;

endmodule
